// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;
   localparam int unsigned XLEN    = 64;
   localparam int unsigned INSTR_W = 32;
   localparam int unsigned PC_STEP = 4;
   localparam int unsigned ENTRY_W = XLEN + INSTR_W;

   localparam logic [XLEN-1:0]    RESET_PC_DEF = '0;
   localparam logic [INSTR_W-1:0] NOP          = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
      return pc & ~XLEN'(3);
   endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries with flush and occupancy count.
module fetch_fifo
   import fetch_unit_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         push,
   input  logic [ENTRY_W-1:0]           wdata,
   input  logic                         pop,
   output logic [ENTRY_W-1:0]           rdata,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               do_push, do_pop;

   always_comb begin
      do_pop   = pop && (count_q != '0);
      do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; contents are only observed while count is nonzero.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
   end

   always_comb begin
      rdata = mem_q[rd_ptr_q];
      empty = (count_q == '0);
      count = count_q;
   end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PC generation, credit-limited memory requests,
// redirect flush with drop of in-flight responses, and a buffered output queue.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req_valid,
   output logic [XLEN-1:0]    imem_req_addr,
   input  logic               imem_req_ready,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   input  logic               redirect_valid,
   input  logic [XLEN-1:0]    redirect_pc,
   output logic               out_valid,
   output logic [INSTR_W-1:0] out_instr,
   output logic [XLEN-1:0]    out_pc,
   input  logic               out_ready
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned SUM_W = CNT_W + 1;

   logic [XLEN-1:0]    req_pc_q, req_pc_d;
   logic [XLEN-1:0]    rsp_pc_q, rsp_pc_d;
   logic [CNT_W-1:0]   outstanding_q, outstanding_d;
   logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
   logic [CNT_W-1:0]   fifo_count;
   logic [SUM_W-1:0]   credit_used;
   logic [XLEN-1:0]    redirect_tgt;
   logic [ENTRY_W-1:0] fifo_rdata;
   logic               fifo_empty;
   logic               fifo_push;
   logic               req_fire;
   fetch_entry_t       push_entry;
   fetch_entry_t       head;

   // Every accepted request owns a FIFO slot, so pushes can never overflow.
   always_comb begin
      credit_used    = SUM_W'(outstanding_q) + SUM_W'(fifo_count);
      imem_req_valid = !rst && !redirect_valid && (credit_used < SUM_W'(DEPTH));
      imem_req_addr  = req_pc_q;
      req_fire       = imem_req_valid && imem_req_ready;
      redirect_tgt   = align_pc(redirect_pc);
      fifo_push      = imem_rsp_valid && !redirect_valid && (drop_cnt_q == '0);
      push_entry     = '{pc: rsp_pc_q, instr: imem_rsp_data};

      req_pc_d      = req_pc_q;
      rsp_pc_d      = rsp_pc_q;
      drop_cnt_d    = drop_cnt_q;
      outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);

      if (req_fire) req_pc_d = req_pc_q + XLEN'(PC_STEP);
      if (imem_rsp_valid) begin
         if (drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - CNT_W'(1);
         else                  rsp_pc_d   = rsp_pc_q + XLEN'(PC_STEP);
      end
      // Everything still in flight after this cycle belongs to the old path.
      if (redirect_valid) begin
         req_pc_d   = redirect_tgt;
         rsp_pc_d   = redirect_tgt;
         drop_cnt_d = outstanding_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req_pc_q      <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
      end else begin
         req_pc_q      <= req_pc_d;
         rsp_pc_q      <= rsp_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (redirect_valid),
      .push  (fifo_push),
      .wdata (push_entry),
      .pop   (out_ready),
      .rdata (fifo_rdata),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      head      = fetch_entry_t'(fifo_rdata);
      out_valid = !fifo_empty;
      out_instr = out_valid ? head.instr : NOP;
      out_pc    = head.pc;
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model plus a program-order reference of expected PCs.
module tb_fetch_unit;
   localparam int unsigned DEPTH = 4;
   localparam logic [63:0] RST_PC = 64'h0;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic [63:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [63:0] out_pc;
   logic        out_ready;

   fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .out_ready      (out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] addr;
      int          due;
   } pend_t;

   pend_t       mq[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          last_due = 0;
   int          lat_lo = 1;
   int          lat_hi = 1;
   int          n_fire = 0;
   int          n_pop = 0;
   logic [63:0] exp_pc = RST_PC;
   logic [63:0] exp_req_pc = RST_PC;
   logic        after_rst = 1'b0;
   logic        redir_prev = 1'b0;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: sample/check at negedge, advance the reference at posedge, drive memory after.
   task automatic cycle();
      logic        s_rst, s_fire, s_pop, s_rsp, s_redir;
      logic [63:0] s_addr, s_tgt;
      pend_t       p;
      int          lat;
      @(negedge clk);
      s_rst   = rst;
      s_rsp   = imem_rsp_valid;
      s_redir = redirect_valid;
      s_tgt   = redirect_pc;
      s_addr  = imem_req_addr;
      s_fire  = imem_req_valid && imem_req_ready;
      s_pop   = out_valid && out_ready;
      if (s_rst) begin
         check("req_valid_in_rst", 64'(imem_req_valid), 64'd0);
      end else begin
         if (after_rst) begin
            check("out_valid_after_rst", 64'(out_valid), 64'd0);
            check("req_addr_after_rst", imem_req_addr, RST_PC);
         end
         if (redir_prev)     check("out_valid_after_redirect", 64'(out_valid), 64'd0);
         if (redirect_valid) check("req_valid_in_redirect", 64'(imem_req_valid), 64'd0);
         if (s_fire) begin
            check("req_addr", s_addr, exp_req_pc);
            check("credit", 64'(mq.size() < DEPTH), 64'd1);
         end
         if (out_valid) begin
            check("out_pc", out_pc, exp_pc);
            check("out_instr", 64'(out_instr), 64'(mem_word(exp_pc)));
         end
      end
      @(posedge clk);
      if (s_rst) begin
         mq.delete();
         exp_pc     = RST_PC;
         exp_req_pc = RST_PC;
         last_due   = cyc;
         after_rst  = 1'b1;
         redir_prev = 1'b0;
      end else begin
         after_rst = 1'b0;
         if (s_pop) begin
            exp_pc += 64'd4;
            n_pop++;
         end
         if (s_fire) begin
            lat    = int'($urandom_range(lat_hi, lat_lo));
            p.addr = s_addr;
            p.due  = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            last_due = p.due;
            mq.push_back(p);
            exp_req_pc += 64'd4;
            n_fire++;
         end
         if (s_rsp && mq.size() != 0) void'(mq.pop_front());
         if (s_redir) begin
            exp_pc     = s_tgt & ~64'h3;
            exp_req_pc = s_tgt & ~64'h3;
         end
         redir_prev = s_redir;
      end
      cyc++;
      #1;
      if (!rst && mq.size() != 0 && mq[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(mq[0].addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      redirect_valid = 1'b0;
      cycle();
      cycle();
      rst = 1'b0;
   endtask

   task automatic expect_first_out(input string tag, input logic [63:0] pc);
      int i;
      i = 0;
      while (!out_valid && i < 40) begin
         cycle();
         i++;
      end
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_pc"}, out_pc, pc);
   endtask

   task automatic redirect_to(input logic [63:0] tgt);
      redirect_valid = 1'b1;
      redirect_pc    = tgt;
      cycle();
      redirect_valid = 1'b0;
   endtask

   int p0, f0;

   initial begin
      rst = 1'b1;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      out_ready      = 1'b1;

      // Streaming memory, latency 1: one instruction per cycle after warm-up.
      do_reset();
      repeat (4) cycle();
      p0 = n_pop;
      repeat (16) cycle();
      check("stream_throughput", 64'(n_pop - p0), 64'd16);

      // Consumer stalled: exactly DEPTH requests then issue stops.
      out_ready = 1'b0;
      do_reset();
      f0 = n_fire;
      repeat (12) cycle();
      check("stall_req_count", 64'(n_fire - f0), 64'(DEPTH));
      check("stall_req_valid", 64'(imem_req_valid), 64'd0);
      out_ready = 1'b1;
      p0 = n_pop;
      repeat (10) cycle();
      check("stall_drain", 64'(n_pop - p0 >= 4), 64'd1);

      // Latency 3, redirect with two requests in flight.
      lat_lo = 3; lat_hi = 3;
      do_reset();
      repeat (2) cycle();
      imem_req_ready = 1'b0;
      redirect_to(64'h100);
      imem_req_ready = 1'b1;
      expect_first_out("redir_inflight", 64'h100);
      repeat (8) cycle();

      // Redirect coinciding with a response (and a would-be request).
      lat_lo = 2; lat_hi = 2;
      for (int i = 0; i < 20; i++) begin
         if (imem_rsp_valid && imem_req_valid) break;
         cycle();
      end
      check("coinc_setup", 64'(imem_rsp_valid && imem_req_valid), 64'd1);
      redirect_to(64'h300);
      expect_first_out("redir_coinc", 64'h300);
      repeat (6) cycle();

      // Unaligned target, back-to-back redirects, and PC wrap.
      redirect_to(64'h203);
      check("align_addr", imem_req_addr, 64'h200);
      expect_first_out("redir_align", 64'h200);
      repeat (3) cycle();
      redirect_valid = 1'b1;
      redirect_pc    = 64'h40;
      cycle();
      redirect_to(64'h80);
      expect_first_out("redir_b2b", 64'h80);
      redirect_to(64'hFFFF_FFFF_FFFF_FFF8);
      repeat (12) cycle();

      // Reset mid-operation with entries buffered and requests outstanding.
      lat_lo = 3; lat_hi = 3;
      out_ready = 1'b0;
      do_reset();
      repeat (5) cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_req_addr", imem_req_addr, RST_PC);
      out_ready = 1'b1;
      repeat (10) cycle();

      // Randomized traffic against the reference.
      lat_lo = 1; lat_hi = 4;
      for (int i = 0; i < 3000; i++) begin
         imem_req_ready = ($urandom % 4) != 0;
         out_ready      = ($urandom % 3) != 0;
         if (($urandom % 20) == 0) begin
            redirect_valid = 1'b1;
            if (($urandom % 4) == 0)
               redirect_pc = {32'hFFFF_FFFF, 32'($urandom_range(32'hFFFF_FFFF, 32'hFFFF_FFE0))};
            else
               redirect_pc = {32'h0, 32'($urandom)};
         end else begin
            redirect_valid = 1'b0;
         end
         rst = (($urandom % 500) == 0);
         if (rst) redirect_valid = 1'b0;
         cycle();
      end
      rst = 1'b0;
      redirect_valid = 1'b0;
      repeat (10) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
